// File: rtl/dest_arb_pkg.sv
// Shared types and the rotate-priority pick helper for the
// destination register file write arbiter.
package dest_arb_pkg;

  localparam int DEST_AW = 3;
  localparam int DEST_DW = 16;
  localparam int MAXREQ  = 8;

  typedef enum logic {
    ST_INIT,
    ST_ARB
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid scanning upward from ptr, modulo n.
  function automatic pick_t rr_pick(
    input logic [MAXREQ-1:0] valid,
    input logic [2:0]        ptr,
    input int                n
  );
    pick_t r;
    int    j;
    r = '0;
    for (int k = MAXREQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (valid[3'(j)]) begin
          r.found = 1'b1;
          r.idx   = 3'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dest_write_arbiter_if.sv
// Requester / register-file side bundle of the destination
// write arbiter.
interface dest_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 3
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               stall;
  logic [NREQ-1:0]    req_ready;
  logic               cap_en;
  logic [AW-1:0]      addr;
  logic [DW-1:0]      wdata;
  logic [IW-1:0]      grant_id;
  logic               init_busy;

  modport master (
    output req_valid, req_addr, req_data, stall,
    input  req_ready, cap_en, addr, wdata,
    input  grant_id, init_busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, stall,
    output req_ready, cap_en, addr, wdata,
    output grant_id, init_busy
  );

endinterface

// File: rtl/dest_rr_picker.sv
// Combinational rotate-priority encoder: valid + start pointer
// to one-hot grant and winner index.
module dest_rr_picker
  import dest_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [MAXREQ-1:0] v8;
  pick_t             p;

  always_comb begin
    v8        = '0;
    v8[N-1:0] = valid;
    p         = rr_pick(v8, 3'(ptr), N);
    found     = p.found;
    idx       = IW'(p.idx);
    grant     = '0;
    if (p.found) grant[IW'(p.idx)] = 1'b1;
  end

endmodule

// File: rtl/dest_write_arbiter.sv
// Round-robin write arbiter for the 8 x 16 destination register file.
// DEST_ARB_INIT_CLEAR_EN adds a post-reset zero sweep of every entry.
module dest_write_arbiter
  import dest_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DEST_DW,
  parameter int AW   = DEST_AW
) (
  input logic                  clk,
  input logic                  rst_n,
  dest_write_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic            cap_q, cap_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            in_init;
  logic [AW-1:0]   sweep_addr;
  logic            xfer;

`ifdef DEST_ARB_INIT_CLEAR_EN
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {AW{1'b1}}) state_d = ST_ARB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_init    = (state_q == ST_INIT);
  assign sweep_addr = cnt_q;
`else
  assign in_init    = 1'b0;
  assign sweep_addr = '0;
`endif

  dest_rr_picker #(.N(NREQ)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign xfer = pick_found & ~in_init & ~bus.stall;

  always_comb begin
    cap_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    if (in_init) begin
      cap_d   = 1'b1;
      addr_d  = sweep_addr;
      wdata_d = '0;
    end else if (xfer) begin
      cap_d   = 1'b1;
      addr_d  = bus.req_addr[pick_idx*AW +: AW];
      wdata_d = bus.req_data[pick_idx*DW +: DW];
      gid_d   = pick_idx;
      ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0
              : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      cap_q   <= cap_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.req_ready = xfer ? pick_gnt : '0;
  assign bus.cap_en    = cap_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.grant_id  = gid_q;
  assign bus.init_busy = in_init;

endmodule

// File: tb/tb_dest_write_arbiter.sv
// Directed + random bench for dest_write_arbiter against a
// behavioural round-robin model and a register file model.
module tb_dest_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic clk;
  logic rst_n;

  dest_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  dest_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf [8];
  always @(posedge clk) begin
    if (bus.cap_en === 1'b1) rf[bus.addr] <= bus.wdata;
  end

  int            m_ptr;
  logic          m_cap;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_gid;
  logic [DW-1:0] exp_mem [8];
  logic [7:0]    written;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_cap   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_gid   = 0;
  endtask

  task automatic step(input logic [NREQ-1:0] v,
                      input logic [NREQ*AW-1:0] a,
                      input logic [NREQ*DW-1:0] d,
                      input logic s);
    int w;
    logic [NREQ-1:0] er;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.stall     = s;
    #1;
    w = -1;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    end
    er = '0;
    if (!s && w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    if (!s && w >= 0) begin
      m_cap   = 1'b1;
      m_addr  = a[w*AW +: AW];
      m_wdata = d[w*DW +: DW];
      m_gid   = w;
      m_ptr   = (w + 1) % NREQ;
      exp_mem[m_addr] = m_wdata;
      written[m_addr] = 1'b1;
    end else begin
      m_cap = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("cap_en", 32'(bus.cap_en), 32'(m_cap));
    chk("addr", 32'(bus.addr), 32'(m_addr));
    chk("wdata", 32'(bus.wdata), 32'(m_wdata));
    chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    chk("init_busy", 32'(bus.init_busy), 32'd0);
  endtask

  task automatic idle();
    step('0, '0, '0, 1'b0);
  endtask

`ifdef DEST_ARB_INIT_CLEAR_EN
  // Called just after rst_n release at a negedge.
  task automatic sweep(input int stop_at);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      bus.req_valid = '1;
      bus.stall     = 1'b0;
      #1;
      chk("sweep_ready", 32'(bus.req_ready), 32'd0);
      chk("sweep_busy", 32'(bus.init_busy), 32'd1);
      @(posedge clk);
      #1;
      chk("sweep_cap", 32'(bus.cap_en), 32'd1);
      chk("sweep_addr", 32'(bus.addr), 32'(i));
      chk("sweep_wdata", 32'(bus.wdata), 32'd0);
      if (i == stop_at) return;
    end
    chk("sweep_done", 32'(bus.init_busy), 32'd0);
  endtask
`endif

  int rot [5] = '{0, 1, 2, 3, 0};
  logic [NREQ*AW-1:0] ra;
  logic [NREQ*DW-1:0] rd;

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.stall     = 1'b0;
    written       = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_cap", 32'(bus.cap_en), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_gid", 32'(bus.grant_id), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
`ifdef DEST_ARB_INIT_CLEAR_EN
    chk("rst_busy", 32'(bus.init_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(3);
    #1 rst_n = 1'b0;
    #1;
    chk("midsweep_cap", 32'(bus.cap_en), 32'd0);
    chk("midsweep_addr", 32'(bus.addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(8);
    m_addr  = 3'd7;
    written = '1;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
`else
    chk("rst_busy", 32'(bus.init_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // all requesters valid: grants rotate from pointer 0
    ra = {3'd3, 3'd2, 3'd1, 3'd0};
    rd = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, ra, rd, 1'b0);
      chk("rot_gid", 32'(bus.grant_id), 32'(rot[i]));
    end
    idle();

    // single requester 2
    step(4'b0100, {3'd0, 3'd5, 3'd0, 3'd0},
         {16'h0, 16'hBEEF, 16'h0, 16'h0}, 1'b0);
    chk("single_gid", 32'(bus.grant_id), 32'd2);
    chk("single_addr", 32'(bus.addr), 32'd5);
    chk("single_data", 32'(bus.wdata), 32'hBEEF);
    idle();
    chk("single_off", 32'(bus.cap_en), 32'd0);

    // move pointer to 1, then stall with 1 and 3 pending
    step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd6},
         {16'h0, 16'h0, 16'h0, 16'h6666}, 1'b0);
    ra = {3'd3, 3'd0, 3'd1, 3'd0};
    rd = {16'hC333, 16'h0, 16'hC111, 16'h0};
    step(4'b1010, ra, rd, 1'b1);
    chk("stall_cap", 32'(bus.cap_en), 32'd0);
    step(4'b1010, ra, rd, 1'b0);
    chk("unstall_first", 32'(bus.grant_id), 32'd1);
    step(4'b1000, ra, rd, 1'b0);
    chk("unstall_second", 32'(bus.grant_id), 32'd3);

    // same address from two requesters: last grant wins
    ra = {3'd0, 3'd0, 3'd4, 3'd4};
    rd = {16'h0, 16'h0, 16'h2222, 16'h1111};
    step(4'b0011, ra, rd, 1'b0);
    step(4'b0010, ra, rd, 1'b0);
    idle();
    chk("same_addr_rf", 32'(rf[4]), 32'h2222);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      step(4'($urandom), 12'($urandom),
           {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
           ($urandom_range(0, 3) == 0));
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      if (written[i]) chk("rf_final", 32'(rf[i]), 32'(exp_mem[i]));
    end

    // reset in the middle of a transfer
    step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd2},
         {16'h0, 16'h0, 16'h0, 16'h7777}, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midxfer_cap", 32'(bus.cap_en), 32'd0);
    chk("midxfer_addr", 32'(bus.addr), 32'd0);
    chk("midxfer_wdata", 32'(bus.wdata), 32'd0);
    chk("midxfer_gid", 32'(bus.grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
